// File: rtl/draw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_scheduler_if
// Description : Requester and frame-drawer signal bundle for draw_scheduler.
//               The scheduler uses the slave modport; the requesters and the
//               drawer (or a testbench standing in for them) use master.
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_scheduler_if #(
    parameter int NUM_REQ = 3
) ();
    logic [NUM_REQ-1:0]   iReq;
    logic [3*NUM_REQ-1:0] iFrame;
    logic [NUM_REQ-1:0]   oGrant;
    logic [NUM_REQ-1:0]   oReqDone;
    logic                 oDrawStart;
    logic [2:0]           oFrameSel;
    logic                 iDrawDone;
    logic                 oDrawAbort;
    logic                 oBusy;
    logic                 oErr;
    logic                 oTimeout;

    modport slave (
        input  iReq, iFrame, iDrawDone,
        output oGrant, oReqDone, oDrawStart, oFrameSel, oDrawAbort,
               oBusy, oErr, oTimeout
    );

    modport master (
        output iReq, iFrame, iDrawDone,
        input  oGrant, oReqDone, oDrawStart, oFrameSel, oDrawAbort,
               oBusy, oErr, oTimeout
    );
endinterface
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : draw_scheduler
// Description : Round-robin arbiter that issues one full-screen frame draw at
//               a time to the frame drawer, with a post-draw hold window and a
//               draw watchdog. Optional macro REDRAW_SKIP_EN suppresses a
//               redraw of the frame that is already on screen.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_scheduler #(
    parameter int NUM_REQ        = 3,
    parameter int HOLD_CYCLES    = 0,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  wire logic         iClock,
    input  wire logic         iReset,
    draw_scheduler_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    // With no hold window the HOLD state takes zero cycles, so skip it.
    localparam logic [1:0] ST_AFTER = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;

    localparam logic [2:0]         FRAME_NONE = 3'd7;
    localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      wd_q, wd_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic               draw_start_q, draw_start_d;
    logic [2:0]         frame_sel_q, frame_sel_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               timeout_q, timeout_d;
`ifdef REDRAW_SKIP_EN
    logic [2:0]         last_q, last_d;
`endif

    logic               w_pick_valid;
    logic [PW-1:0]      w_pick_idx;
    logic [2:0]         w_pick_frame;
    logic               w_skip;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin : p_pick
        int j;
        j            = 0;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.iReq[j]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = PW'(j);
            end
        end
        w_pick_frame = bus.iFrame[3*int'(w_pick_idx) +: 3];
`ifdef REDRAW_SKIP_EN
        w_skip = (w_pick_frame == last_q);
`else
        w_skip = 1'b0;
`endif
    end

    // Next-state and output decode; all outputs are registered pulses/levels.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        wd_d         = wd_q;
        hold_d       = hold_q;
        grant_d      = '0;
        req_done_d   = '0;
        draw_start_d = 1'b0;
        frame_sel_d  = frame_sel_q;
        abort_d      = 1'b0;
        err_d        = err_q;
        timeout_d    = timeout_q;
`ifdef REDRAW_SKIP_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                wd_d   = '0;
                hold_d = '0;
                if (w_pick_valid) begin
                    idx_d   = w_pick_idx;
                    grant_d = ONE << w_pick_idx;
                    state_d = ST_ISSUE;
                    if (w_pick_frame == FRAME_NONE) begin
                        err_d = 1'b1;
                    end else if (!w_skip) begin
                        draw_start_d = 1'b1;
                        frame_sel_d  = w_pick_frame;
                    end
                end
            end
            ST_ISSUE: begin
                ptr_d = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + PW'(1);
                // Watchdog starts at zero on the start pulse cycle, so the
                // abort lands exactly TIMEOUT_CYCLES after oDrawStart.
                wd_d  = wd_q + TW'(1);
                if (draw_start_q) begin
                    state_d = ST_DRAW;
                end else begin
                    req_done_d = ONE << idx_q;
                    state_d    = ST_AFTER;
                end
            end
            ST_DRAW: begin
                if (bus.iDrawDone) begin
                    req_done_d = ONE << idx_q;
                    state_d    = ST_AFTER;
`ifdef REDRAW_SKIP_EN
                    last_d     = frame_sel_q;
`endif
                end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    abort_d    = 1'b1;
                    timeout_d  = 1'b1;
                    req_done_d = ONE << idx_q;
                    state_d    = ST_AFTER;
`ifdef REDRAW_SKIP_EN
                    last_d     = FRAME_NONE;
`endif
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            default: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            wd_q         <= '0;
            hold_q       <= '0;
            grant_q      <= '0;
            req_done_q   <= '0;
            draw_start_q <= 1'b0;
            frame_sel_q  <= '0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef REDRAW_SKIP_EN
            last_q       <= FRAME_NONE;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            grant_q      <= grant_d;
            req_done_q   <= req_done_d;
            draw_start_q <= draw_start_d;
            frame_sel_q  <= frame_sel_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
`ifdef REDRAW_SKIP_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus.oGrant     = grant_q;
    assign bus.oReqDone   = req_done_q;
    assign bus.oDrawStart = draw_start_q;
    assign bus.oFrameSel  = frame_sel_q;
    assign bus.oDrawAbort = abort_q;
    assign bus.oBusy      = busy_q;
    assign bus.oErr       = err_q;
    assign bus.oTimeout   = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_scheduler
// Description : Randomized scoreboard bench for draw_scheduler. A transaction
//               model predicts grant/done timing from the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_scheduler;
    localparam int NUM_REQ = 3;
    localparam int H       = 3;
    localparam int T       = 40;
    localparam int BIG     = 1 << 30;
`ifdef REDRAW_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic iClock = 1'b0;
    logic iReset;
    always #5 iClock = ~iClock;

    draw_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    draw_scheduler #(
        .NUM_REQ(NUM_REQ), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus(bus)
    );

    typedef struct { int cyc; int idx; bit start; int frame; } grant_t;
    typedef struct { int cyc; int idx; bit abort; } done_t;
    grant_t gq[$];
    done_t  dq[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit gen_en = 1'b1;

    // Reference model state
    int req [NUM_REQ];
    int fr [NUM_REQ];
    int drop_at [NUM_REQ];
    int ptr, last, idle_at, done_at, force_l;
    int err_from, tmo_from, busy_beg, busy_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents one.
    always @(negedge iClock) begin
        grant_t g;
        done_t  d;
        if (mon_en) begin
            if (bus.oGrant !== '0 || bus.oDrawStart !== 1'b0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.oGrant), 0);
                end else begin
                    g = gq.pop_front();
                    chk("grant_cycle", cyc, g.cyc);
                    chk("grant_vec", 32'(bus.oGrant), 1 << g.idx);
                    chk("draw_start", 32'(bus.oDrawStart), 32'(g.start));
                    if (g.start) chk("frame_sel", 32'(bus.oFrameSel), g.frame);
                end
            end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                chk("missing_grant", 0, 1 << g.idx);
            end
            if (bus.oReqDone !== '0 || bus.oDrawAbort !== 1'b0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(bus.oReqDone), 0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("req_done_vec", 32'(bus.oReqDone), 1 << d.idx);
                    chk("draw_abort", 32'(bus.oDrawAbort), 32'(d.abort));
                end
            end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                d = dq.pop_front();
                chk("missing_done", 0, 1 << d.idx);
            end
            chk("err", 32'(bus.oErr), 32'(cyc >= err_from));
            chk("timeout", 32'(bus.oTimeout), 32'(cyc >= tmo_from));
            chk("busy", 32'(bus.oBusy), 32'(cyc >= busy_beg && cyc < busy_end));
        end
    end

    function automatic int pick_latency();
        int r;
        if (force_l > 0) return force_l;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 1;
            1:       return T - 1;
            2, 3:    return T + $urandom_range(0, 2);
            default: return $urandom_range(1, T - 1);
        endcase
    endfunction

    // One cycle of stimulus plus model bookkeeping, run just after posedge.
    task automatic step();
        int k, g, f, l, any;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drop_at[i] == cyc) begin
                req[i]     = 0;
                drop_at[i] = -1;
            end else if (req[i] == 0) begin
                fr[i] = $urandom_range(0, 7);
                if (gen_en && $urandom_range(0, 3) == 0) req[i] = 1;
            end
        end
        any = 0;
        for (int i = 0; i < NUM_REQ; i++) any = any | req[i];
        if (cyc >= idle_at && any != 0) begin
            k = 0;
            for (int o = NUM_REQ - 1; o >= 0; o--)
                if (req[(ptr + o) % NUM_REQ] != 0) k = (ptr + o) % NUM_REQ;
            g          = cyc + 1;
            f          = fr[k];
            ptr        = (k + 1) % NUM_REQ;
            drop_at[k] = g + 1;
            busy_beg   = g;
            if (f == 7) begin
                if (err_from > g) err_from = g;
                gq.push_back('{g, k, 1'b0, f});
                dq.push_back('{g + 1, k, 1'b0});
                idle_at = g + 1 + H;
            end else if (SKIP && f == last) begin
                gq.push_back('{g, k, 1'b0, f});
                dq.push_back('{g + 1, k, 1'b0});
                idle_at = g + 1 + H;
            end else begin
                l = pick_latency();
                gq.push_back('{g, k, 1'b1, f});
                done_at = g + l;
                if (l <= T - 1) begin
                    dq.push_back('{g + l + 1, k, 1'b0});
                    idle_at = g + l + 1 + H;
                    last    = f;
                end else begin
                    dq.push_back('{g + T, k, 1'b1});
                    if (tmo_from > g + T) tmo_from = g + T;
                    idle_at = g + T + H;
                    last    = 7;
                end
            end
            busy_end = idle_at;
        end
        bus.iDrawDone = (cyc == done_at);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.iReq[i]          = (req[i] != 0);
            bus.iFrame[3*i +: 3] = 3'(fr[i]);
        end
    endtask

    task automatic next_cycle();
        @(posedge iClock);
        #1;
        cyc++;
        step();
    endtask

    initial begin
        int waited;
        iReset        = 1'b1;
        bus.iReq      = '0;
        bus.iFrame    = '0;
        bus.iDrawDone = 1'b0;
        repeat (3) @(posedge iClock);
        #1;
        chk("rst_grant", 32'(bus.oGrant), 0);
        chk("rst_req_done", 32'(bus.oReqDone), 0);
        chk("rst_draw_start", 32'(bus.oDrawStart), 0);
        chk("rst_frame_sel", 32'(bus.oFrameSel), 0);
        chk("rst_abort", 32'(bus.oDrawAbort), 0);
        chk("rst_busy", 32'(bus.oBusy), 0);
        chk("rst_err", 32'(bus.oErr), 0);
        chk("rst_timeout", 32'(bus.oTimeout), 0);

        iReset = 1'b0;
        cyc = 0; ptr = 0; last = 7; idle_at = 0; done_at = -1; force_l = 0;
        err_from = BIG; tmo_from = BIG; busy_beg = BIG; busy_end = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = 0; fr[i] = 0; drop_at[i] = -1;
        end
        mon_en = 1'b1;
        step();
        for (int n = 0; n < 4000; n++) next_cycle();

        // Drain: stop new requests and let outstanding work finish.
        gen_en = 1'b0;
        waited = 0;
        while (!(cyc >= idle_at && cyc > done_at && req[0] == 0 && req[1] == 0 && req[2] == 0)
               && waited < 500) begin
            next_cycle();
            waited++;
        end
        chk("drain_bound", 32'(waited < 500), 1);
        next_cycle();
        chk("leftover_grants", gq.size(), 0);
        chk("leftover_dones", dq.size(), 0);

        // Directed: start a long draw of frame 2 and reset in the middle of it.
        @(posedge iClock);
        #1;
        cyc++;
        req[0]  = 1;
        fr[0]   = 2;
        force_l = T - 1;
        drop_at[0] = -1;
        step();
        force_l = 0;
        repeat (3) next_cycle();
        @(posedge iClock);
        #1;
        cyc++;
        mon_en        = 1'b0;
        iReset        = 1'b1;
        bus.iDrawDone = 1'b0;
        bus.iReq      = '0;
        @(posedge iClock);
        #1;
        cyc++;
        chk("mid_rst_grant", 32'(bus.oGrant), 0);
        chk("mid_rst_req_done", 32'(bus.oReqDone), 0);
        chk("mid_rst_draw_start", 32'(bus.oDrawStart), 0);
        chk("mid_rst_frame_sel", 32'(bus.oFrameSel), 0);
        chk("mid_rst_abort", 32'(bus.oDrawAbort), 0);
        chk("mid_rst_busy", 32'(bus.oBusy), 0);
        chk("mid_rst_err", 32'(bus.oErr), 0);
        chk("mid_rst_timeout", 32'(bus.oTimeout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
